// File: rtl/bldc_hall_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bldc_hall_pkg
//  Purpose  : Shared Hall-code constants, sector lookup, FSM state encoding
//             and the mod-6 sector delta helper for the BLDC Hall decoder.
//  Revision : 1.0  initial release
// ============================================================================
package bldc_hall_pkg;

    // Legal Hall codes {w,v,u} in forward rotation order (sector 0..5)
    localparam logic [2:0] c_hall_s0 = 3'b001;
    localparam logic [2:0] c_hall_s1 = 3'b011;
    localparam logic [2:0] c_hall_s2 = 3'b010;
    localparam logic [2:0] c_hall_s3 = 3'b110;
    localparam logic [2:0] c_hall_s4 = 3'b100;
    localparam logic [2:0] c_hall_s5 = 3'b101;

    // Sector deltas that represent a single legal step
    localparam logic [2:0] c_delta_fwd = 3'd1;
    localparam logic [2:0] c_delta_rev = 3'd5;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } hall_state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] sector;
    } hall_lut_t;

    // Hall code to sector; 000 and 111 come back flagged illegal
    function automatic hall_lut_t hall_lookup(input logic [2:0] code);
        hall_lut_t r;
        r.legal  = 1'b1;
        r.sector = 3'd0;
        case (code)
            c_hall_s0: r.sector = 3'd0;
            c_hall_s1: r.sector = 3'd1;
            c_hall_s2: r.sector = 3'd2;
            c_hall_s3: r.sector = 3'd3;
            c_hall_s4: r.sector = 3'd4;
            c_hall_s5: r.sector = 3'd5;
            default:   r.legal  = 1'b0;
        endcase
        return r;
    endfunction

    // (new - old) mod 6 for sectors in 0..5
    function automatic logic [2:0] sector_delta(input logic [2:0] new_s,
                                                input logic [2:0] old_s);
        logic [3:0] t;
        t = {1'b0, new_s} + 4'd6 - {1'b0, old_s};
        if (new_s >= old_s) begin
            return new_s - old_s;
        end
        return t[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hall_filter.sv
`default_nettype none
// ============================================================================
//  Module   : hall_filter
//  Purpose  : 2-FF synchroniser plus FILTER_LEN-cycle debounce for the 3-bit
//             Hall code. Emits the accepted code and a one-cycle strobe
//             whenever the accepted code changes.
//  Revision : 1.0  initial release
// ============================================================================
module hall_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    output logic [2:0] code,
    output logic       new_code
);

    localparam logic [7:0] c_last = 8'(FILTER_LEN - 1);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_cand;
    logic [7:0] r_cnt;
    logic [2:0] r_code;
    logic       r_new_code;

    // Two-stage synchroniser for the asynchronous Hall pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= code_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: any change reloads the candidate; the strobe fires only when
    // a stable candidate differs from the code already accepted, so the
    // reset value of the synchroniser never produces a spurious event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand     <= 3'b000;
            r_cnt      <= 8'd0;
            r_code     <= 3'b000;
            r_new_code <= 1'b0;
        end else begin
            r_new_code <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= 8'd0;
                if ((c_last == 8'd0) && (r_sync2 != r_code)) begin
                    r_code     <= r_sync2;
                    r_new_code <= 1'b1;
                end
            end else if (r_cnt != c_last) begin
                r_cnt <= r_cnt + 8'd1;
                if (((r_cnt + 8'd1) == c_last) && (r_cand != r_code)) begin
                    r_code     <= r_cand;
                    r_new_code <= 1'b1;
                end
            end
        end
    end

    assign code     = r_code;
    assign new_code = r_new_code;

endmodule
`default_nettype wire

// File: rtl/bldc_hall_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bldc_hall_decoder
//  Purpose  : Decodes BLDC Hall sensors into wrapping electrical position,
//             direction, step strobe and step period; flags illegal codes
//             and skipped sectors.
//  Options  : BLDC_HALL_ERRCNT_EN adds the saturating err_count output.
//  Revision : 1.0  initial release
// ============================================================================
module bldc_hall_decoder
    import bldc_hall_pkg::*;
#(
    parameter int FILTER_LEN   = 4,
    parameter int SECTOR_STEPS = 16,
    parameter int TIMEOUT      = 1000000,
    parameter int HALL_INVERT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hall_u,
    input  logic        hall_v,
    input  logic        hall_w,
    input  logic        clear_error,
    output logic [15:0] position,
    output logic [2:0]  sector,
    output logic        direction,
    output logic        step,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        hall_error,
    output logic        locked
`ifdef BLDC_HALL_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [2:0]  c_hall_inv = (HALL_INVERT != 0) ? 3'b111 : 3'b000;
    localparam logic [15:0] c_step     = 16'(SECTOR_STEPS);
    localparam logic [31:0] c_timeout  = 32'(TIMEOUT);

    logic [2:0]  w_raw_code;
    logic [2:0]  w_code;
    logic        w_new_code;
    hall_lut_t   w_lut;
    logic [2:0]  w_delta;
    logic        w_timeout;
    logic        w_is_fwd;
    logic        w_is_rev;
    logic        w_illegal_evt;
    logic        w_skip_evt;
    logic        w_err_evt;

    hall_state_t r_state;
    logic [15:0] r_position;
    logic [2:0]  r_sector;
    logic        r_direction;
    logic        r_step;
    logic [31:0] r_period;
    logic        r_period_valid;
    logic        r_hall_error;
    logic        r_locked;
    logic [31:0] r_timer;
    logic        r_have_dir;

    assign w_raw_code = {hall_w, hall_v, hall_u} ^ c_hall_inv;

    hall_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .code_in  (w_raw_code),
        .code     (w_code),
        .new_code (w_new_code)
    );

    assign w_lut     = hall_lookup(w_code);
    assign w_delta   = sector_delta(w_lut.sector, r_sector);
    assign w_timeout = (r_timer == c_timeout);
    assign w_is_fwd  = (w_delta == c_delta_fwd);
    assign w_is_rev  = (w_delta == c_delta_rev);

    assign w_illegal_evt = w_new_code && !w_lut.legal;
    assign w_skip_evt    = w_new_code && w_lut.legal && (r_state == ST_RUN) &&
                           (w_lut.sector != r_sector) && !w_is_fwd && !w_is_rev;
    assign w_err_evt     = w_illegal_evt || w_skip_evt;

    // Sector tracking FSM with position, direction and period measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_INIT;
            r_position     <= 16'd0;
            r_sector       <= 3'd0;
            r_direction    <= 1'b0;
            r_step         <= 1'b0;
            r_period       <= 32'd0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timer        <= 32'd0;
            r_have_dir     <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (!w_timeout) begin
                r_timer <= r_timer + 32'd1;
            end else begin
                // Stopped: invalidate the period and forget the last
                // direction so a saturated timer is never reported.
                r_period       <= 32'd0;
                r_period_valid <= 1'b0;
                r_have_dir     <= 1'b0;
            end

            if (w_new_code && w_lut.legal) begin
                case (r_state)
                    ST_INIT: begin
                        r_sector   <= w_lut.sector;
                        r_position <= 16'({13'd0, w_lut.sector} * c_step);
                        r_locked   <= 1'b1;
                        r_timer    <= 32'd0;
                        r_state    <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (w_lut.sector != r_sector) begin
                            r_sector <= w_lut.sector;
                            r_timer  <= 32'd0;
                            if (w_is_fwd || w_is_rev) begin
                                r_position  <= w_is_fwd ? (r_position + c_step)
                                                        : (r_position - c_step);
                                r_direction <= w_is_rev;
                                r_step      <= 1'b1;
                                r_have_dir  <= 1'b1;
                                if (r_have_dir && (r_direction == w_is_rev) && !w_timeout) begin
                                    r_period       <= r_timer + 32'd1;
                                    r_period_valid <= 1'b1;
                                end else begin
                                    r_period_valid <= 1'b0;
                                end
                            end else begin
                                // Skipped sector: resync, no step, restart timing
                                r_period_valid <= 1'b0;
                                r_have_dir     <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

    // Sticky error flag; a new error in the clearing cycle keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hall_error <= 1'b0;
        end else if (w_err_evt) begin
            r_hall_error <= 1'b1;
        end else if (clear_error) begin
            r_hall_error <= 1'b0;
        end
    end

`ifdef BLDC_HALL_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating count of illegal-code and skipped-sector events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (clear_error) begin
            r_err_count <= w_err_evt ? 8'd1 : 8'd0;
        end else if (w_err_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign position     = r_position;
    assign sector       = r_sector;
    assign direction    = r_direction;
    assign step         = r_step;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign hall_error   = r_hall_error;
    assign locked       = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_bldc_hall_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bldc_hall_decoder
//  Purpose  : Self-checking bench for bldc_hall_decoder (FILTER_LEN=4,
//             SECTOR_STEPS=16, TIMEOUT=1000). Table of Hall steps with a
//             scoreboard queue, plus hand sequences for glitch, faults,
//             error/clear race, timeout and mid-run reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bldc_hall_decoder;

    localparam int FL  = 4;
    localparam int SS  = 16;
    localparam int TO  = 1000;
    localparam int GAP = 200;
    localparam int LAT = FL + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hall_u = 1'b0;
    logic        hall_v = 1'b0;
    logic        hall_w = 1'b0;
    logic        clear_error = 1'b0;
    logic [15:0] position;
    logic [2:0]  sector;
    logic        direction;
    logic        step;
    logic [31:0] period;
    logic        period_valid;
    logic        hall_error;
    logic        locked;
`ifdef BLDC_HALL_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    bldc_hall_decoder #(
        .FILTER_LEN   (FL),
        .SECTOR_STEPS (SS),
        .TIMEOUT      (TO),
        .HALL_INVERT  (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_u       (hall_u),
        .hall_v       (hall_v),
        .hall_w       (hall_w),
        .clear_error  (clear_error),
        .position     (position),
        .sector       (sector),
        .direction    (direction),
        .step         (step),
        .period       (period),
        .period_valid (period_valid),
        .hall_error   (hall_error),
        .locked       (locked)
`ifdef BLDC_HALL_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    typedef struct {
        bit          do_rst;
        logic [2:0]  code;
        logic [2:0]  sec;
        logic [15:0] pos;
        logic        dir;
        logic        stp;
        logic        pv;
        logic [31:0] per;
        logic        err;
        logic        lck;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   step_cnt = 0;

    // Count step pulses as seen at the sampling edge
    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c);
        {hall_w, hall_v, hall_u} = c;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000);
        cycles(2);
        rst = 1'b0;
    endtask

    // Apply a legal step, check position after the pipeline latency
    task automatic apply(input logic [2:0] c, input logic [15:0] exp_pos, input string nm);
        drive(c);
        cycles(LAT);
        chk(nm, 32'(position), 32'(exp_pos));
        cycles(20);
    endtask

    function automatic vec_t mk(bit r, logic [2:0] c, logic [2:0] s, logic [15:0] p,
                                logic d, logic st, logic pv, logic [31:0] pe,
                                logic e, logic l);
        vec_t v;
        v.do_rst = r; v.code = c; v.sec = s; v.pos = p; v.dir = d;
        v.stp = st; v.pv = pv; v.per = pe; v.err = e; v.lck = l;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        vec_t e;

        //            rst  code    sec  pos     dir stp pv per  err lck
        vecs[0]  = mk(1, 3'b011, 3'd1, 16'd16,    0, 0, 0, 0,   0, 1);
        vecs[1]  = mk(0, 3'b010, 3'd2, 16'd32,    0, 1, 0, 0,   0, 1);
        vecs[2]  = mk(0, 3'b110, 3'd3, 16'd48,    0, 1, 1, 200, 0, 1);
        vecs[3]  = mk(0, 3'b100, 3'd4, 16'd64,    0, 1, 1, 200, 0, 1);
        vecs[4]  = mk(0, 3'b101, 3'd5, 16'd80,    0, 1, 1, 200, 0, 1);
        vecs[5]  = mk(0, 3'b001, 3'd0, 16'd96,    0, 1, 1, 200, 0, 1);
        vecs[6]  = mk(0, 3'b011, 3'd1, 16'd112,   0, 1, 1, 200, 0, 1);
        vecs[7]  = mk(0, 3'b001, 3'd0, 16'd96,    1, 1, 0, 200, 0, 1);
        vecs[8]  = mk(0, 3'b101, 3'd5, 16'd80,    1, 1, 1, 200, 0, 1);
        vecs[9]  = mk(1, 3'b011, 3'd1, 16'd16,    0, 0, 0, 0,   0, 1);
        vecs[10] = mk(0, 3'b001, 3'd0, 16'd0,     1, 1, 0, 0,   0, 1);
        vecs[11] = mk(0, 3'b101, 3'd5, 16'd65520, 1, 1, 1, 200, 0, 1);

        // Reset state
        cycles(3);
        chk("reset.position", 32'(position), 0);
        chk("reset.locked", 32'(locked), 0);
        chk("reset.period", period, 0);
        chk("reset.flags", {27'd0, sector, direction, step}, 0);

        // Table-driven steps, expectations flow through the scoreboard
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_rst) do_reset();
            drive(vecs[i].code);
            sb_q.push_back(vecs[i]);
            cycles(LAT);
            e = sb_q.pop_front();
            chk($sformatf("v%0d.sector", i), 32'(sector), 32'(e.sec));
            chk($sformatf("v%0d.position", i), 32'(position), 32'(e.pos));
            chk($sformatf("v%0d.direction", i), 32'(direction), 32'(e.dir));
            chk($sformatf("v%0d.step", i), 32'(step), 32'(e.stp));
            chk($sformatf("v%0d.period_valid", i), 32'(period_valid), 32'(e.pv));
            chk($sformatf("v%0d.period", i), period, e.per);
            chk($sformatf("v%0d.hall_error", i), 32'(hall_error), 32'(e.err));
            chk($sformatf("v%0d.locked", i), 32'(locked), 32'(e.lck));
            cycles(GAP - LAT);
        end
        chk("sb_empty", 32'(sb_q.size()), 0);

        // Reverse down to sector 2 with a 27-cycle step gap
        apply(3'b100, 16'd65504, "rev.s4");
        apply(3'b110, 16'd65488, "rev.s3");
        apply(3'b010, 16'd65472, "rev.s2");
        chk("rev.period", period, 32'(LAT + 20));
        chk("rev.period_valid", 32'(period_valid), 1);

        // Glitch shorter than the filter window
        s0 = step_cnt;
        drive(3'b110);
        cycles(3);
        drive(3'b010);
        cycles(20);
        chk("glitch.position", 32'(position), 65472);
        chk("glitch.sector", 32'(sector), 2);
        chk("glitch.hall_error", 32'(hall_error), 0);
        chk("glitch.steps", 32'(step_cnt), 32'(s0));

        // Illegal code, then a skipped sector
        drive(3'b111);
        cycles(10);
        chk("illegal.hall_error", 32'(hall_error), 1);
        chk("illegal.position", 32'(position), 65472);
        chk("illegal.sector", 32'(sector), 2);
        chk("illegal.locked", 32'(locked), 1);
        drive(3'b010);
        cycles(10);
        chk("illegal.sticky", 32'(hall_error), 1);
        drive(3'b100);
        cycles(LAT);
        chk("skip.sector", 32'(sector), 4);
        chk("skip.position", 32'(position), 65472);
        chk("skip.period_valid", 32'(period_valid), 0);
        chk("skip.steps", 32'(step_cnt), 32'(s0));
        cycles(5);
        clear_error = 1'b1;
        cycles(1);
        clear_error = 1'b0;
        chk("clear.hall_error", 32'(hall_error), 0);

        // Skip 4 -> 0 landing on the same edge as clear_error: error wins
        drive(3'b001);
        cycles(LAT - 1);
        clear_error = 1'b1;
        cycles(1);
        clear_error = 1'b0;
        chk("race.hall_error", 32'(hall_error), 1);
        chk("race.sector", 32'(sector), 0);
        cycles(3);
        clear_error = 1'b1;
        cycles(1);
        clear_error = 1'b0;
        chk("race.cleared", 32'(hall_error), 0);

        // Timeout: period held before TIMEOUT, zero after
        cycles(400);
        chk("pre_timeout.period", period, 32'(LAT + 20));
        cycles(700);
        chk("timeout.period", period, 0);
        chk("timeout.period_valid", 32'(period_valid), 0);

        // Mid-run reset with an error pending, then re-lock latency
        drive(3'b111);
        cycles(10);
        chk("prereset.hall_error", 32'(hall_error), 1);
        rst = 1'b1;
        drive(3'b100);
        cycles(1);
        chk("midreset.position", 32'(position), 0);
        chk("midreset.locked", 32'(locked), 0);
        chk("midreset.hall_error", 32'(hall_error), 0);
        chk("midreset.others", {28'd0, sector, direction} | 32'(step) | period
                               | 32'(period_valid), 0);
        cycles(1);
        rst = 1'b0;
        cycles(LAT - 1);
        chk("relock.early", 32'(locked), 0);
        cycles(1);
        chk("relock.locked", 32'(locked), 1);
        chk("relock.sector", 32'(sector), 4);
        chk("relock.position", 32'(position), 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
